// File: rtl/prog_loader_if.sv
// Loader bus: session control, byte-stream source handshake, instruction-memory
// write port and session status.
//   master : drives start/base_addr/count/abort and the in_valid/in_data stream
//   slave  : the loader; drives in_ready, inst_* write port, busy/cpu_hold/done/checksum
interface prog_loader_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] inst_data;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic [DATA_W-1:0] checksum;

    modport master (
        output start, base_addr, count, abort, in_valid, in_data,
        input  in_ready, inst_we, inst_address, inst_data, busy, cpu_hold, done, checksum
    );

    modport slave (
        input  start, base_addr, count, abort, in_valid, in_data,
        output in_ready, inst_we, inst_address, inst_data, busy, cpu_hold, done, checksum
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams bytes from a valid/ready source into instruction memory
// starting at a base address, one write per accepted byte, with a running checksum.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   loader_bus  : prog_loader_if slave (session control, byte stream, memory write
//                 port, busy/cpu_hold/done/checksum status)
module prog_loader (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  loader_bus
);
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_checksum;
    logic              r_in_ready;
    logic              r_inst_we;
    logic              r_busy;
    logic              r_done;

    logic              w_session_start;
    logic              w_accept;
    logic              w_advance;
    logic              w_write;

    // Next-state and datapath enables
    always_comb begin
        w_state_nxt     = r_state;
        w_session_start = 1'b0;
        w_accept        = 1'b0;
        w_advance       = 1'b0;
        w_write         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // start outranks abort here, so no abort check
                if (loader_bus.start) begin
                    w_session_start = 1'b1;
                    w_state_nxt     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // abort wins over a byte offered in the same cycle
                if (loader_bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (loader_bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // the write of this cycle always completes, even under abort
                w_write = 1'b1;
                if (loader_bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_remaining == ADDR_W'(0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address, remaining count, write data and checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_checksum  <= '0;
        end else begin
            if (w_session_start) begin
                r_addr      <= loader_bus.base_addr;
                r_remaining <= loader_bus.count;
            end else if (w_advance) begin
                // 7-bit increment wraps 127 -> 0 by design
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - ADDR_W'(1);
            end

            if (w_accept) begin
                r_data <= loader_bus.in_data;
            end

            if (w_session_start) begin
                r_checksum <= '0;
            end else if (w_write) begin
                r_checksum <= r_checksum + r_data;
            end
        end
    end

    // Status outputs registered from the next state so they line up with r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_inst_we  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_LOAD);
            r_inst_we  <= (w_state_nxt == ST_WRITE);
            r_busy     <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_WRITE);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign loader_bus.in_ready     = r_in_ready;
    assign loader_bus.inst_we      = r_inst_we;
    assign loader_bus.inst_address = r_addr;
    assign loader_bus.inst_data    = r_data;
    assign loader_bus.busy         = r_busy;
    assign loader_bus.cpu_hold     = r_busy;
    assign loader_bus.done         = r_done;
    assign loader_bus.checksum     = r_checksum;

endmodule
